// File: rtl/mem_sram_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_sram_ctrl_if
// Pipeline-side bus between the EXE/MEM pipeline register and mem_sram_ctrl.
//
// Signals:
//   mem_r_en  - load request, held stable while ready=0
//   mem_w_en  - store request, held stable while ready=0
//   alu_res   - 32-bit byte address from the execute stage
//   st_val    - 32-bit store data
//   rd_data   - 32-bit load data, valid when ready=1 in the DONE cycle
//   ready     - 0 freezes the pipeline, 1 lets the MEM stage advance
//   addr_err  - sticky out-of-range flag (only when MEM_ADDR_CHECK_EN is defined)
//
// Modports:
//   master - pipeline side (drives requests, receives data/ready)
//   slave  - controller side
//
// Optional feature macro: MEM_ADDR_CHECK_EN
// ---------------------------------------------------------------------------
interface mem_sram_ctrl_if;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] alu_res;
    logic [31:0] st_val;
    logic [31:0] rd_data;
    logic        ready;
`ifdef MEM_ADDR_CHECK_EN
    logic        addr_err;

    modport master (
        output mem_r_en, mem_w_en, alu_res, st_val,
        input  rd_data, ready, addr_err
    );

    modport slave (
        input  mem_r_en, mem_w_en, alu_res, st_val,
        output rd_data, ready, addr_err
    );
`else
    modport master (
        output mem_r_en, mem_w_en, alu_res, st_val,
        input  rd_data, ready
    );

    modport slave (
        input  mem_r_en, mem_w_en, alu_res, st_val,
        output rd_data, ready
    );
`endif
endinterface

// File: rtl/mem_sram_ctrl.sv
// ---------------------------------------------------------------------------
// mem_sram_ctrl
// Memory-stage responder: turns one 32-bit load/store into two 16-bit SRAM
// accesses (low half first), each lasting WAIT_CYCLES clocks, and holds
// ready low until the whole word has been transferred.
//
// Parameters:
//   ADDR_BASE   - byte address mapped to SRAM word 0
//   WAIT_CYCLES - clocks per 16-bit half access (>= 1)
//   SRAM_AW     - SRAM address width in 16-bit halfwords
//
// Ports:
//   clk          - system clock, rising edge
//   rst_n        - asynchronous active-low reset
//   bus          - pipeline-side bus (mem_sram_ctrl_if.slave)
//   sram_addr    - halfword address to the SRAM
//   sram_dq_out  - write data to the SRAM
//   sram_dq_in   - read data from the SRAM
//   sram_dq_oe   - 1 = drive sram_dq_out onto the data bus
//   sram_we_n    - SRAM write strobe, active-low
//
// Optional feature macro: MEM_ADDR_CHECK_EN
//   When defined, out-of-range requests are rejected in IDLE without any SRAM
//   cycle and set the sticky bus.addr_err flag. When undefined, addresses wrap
//   modulo the SRAM size.
// ---------------------------------------------------------------------------
module mem_sram_ctrl #(
    parameter logic [31:0] ADDR_BASE   = 32'd1024,
    parameter int          WAIT_CYCLES = 5,
    parameter int          SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_sram_ctrl_if.slave     bus,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam int               CNT_W    = $clog2(WAIT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   counter, counter_nxt;
    logic               is_wr, is_wr_nxt;
    logic [SRAM_AW-2:0] word_q, word_nxt;
    logic [31:0]        st_q, st_nxt;
    logic [31:0]        rd_q, rd_nxt;
    logic [SRAM_AW-1:0] addr_nxt;
    logic [15:0]        dq_nxt;
    logic               oe_nxt;
    logic               we_n_nxt;
    logic               ready_c;
    logic               start;
    logic               req;
    logic [31:0]        offset;
    logic               unused_bits;

    assign req    = bus.mem_r_en | bus.mem_w_en;
    assign offset = bus.alu_res - ADDR_BASE;

    // Byte offset bits and bits above the SRAM word range never select a
    // halfword; they only matter to the optional range check.
    assign unused_bits = ^{offset[1:0], offset[31:SRAM_AW+1]};

`ifdef MEM_ADDR_CHECK_EN
    logic err_q, err_nxt;
    logic out_of_range;

    // word >= 2^(SRAM_AW-1) is the same as any offset bit above SRAM_AW being set
    assign out_of_range = (bus.alu_res < ADDR_BASE) || (offset[31:SRAM_AW+1] != '0);
    assign bus.addr_err = err_q;
`endif

    assign bus.rd_data = rd_q;
    assign bus.ready   = ready_c;

    // State and SRAM pin registers. The SRAM pins are registered so they change
    // only on clock edges; an async reset drops the write strobe immediately,
    // which may leave a write half done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            counter     <= '0;
            is_wr       <= 1'b0;
            word_q      <= '0;
            st_q        <= '0;
            rd_q        <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
`ifdef MEM_ADDR_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            counter     <= counter_nxt;
            is_wr       <= is_wr_nxt;
            word_q      <= word_nxt;
            st_q        <= st_nxt;
            rd_q        <= rd_nxt;
            sram_addr   <= addr_nxt;
            sram_dq_out <= dq_nxt;
            sram_dq_oe  <= oe_nxt;
            sram_we_n   <= we_n_nxt;
`ifdef MEM_ADDR_CHECK_EN
            err_q       <= err_nxt;
`endif
        end
    end

    // Next-state and output logic. The pin values for the upcoming phase are
    // computed on the transition into it, so the SRAM sees a stable address
    // and strobe for the full WAIT_CYCLES of each half. The strobe stays low
    // across the LO->HI boundary; the SRAM latches on the address change.
    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        is_wr_nxt   = is_wr;
        word_nxt    = word_q;
        st_nxt      = st_q;
        rd_nxt      = rd_q;
        addr_nxt    = sram_addr;
        dq_nxt      = sram_dq_out;
        oe_nxt      = sram_dq_oe;
        we_n_nxt    = sram_we_n;
        ready_c     = 1'b0;
        start       = 1'b0;
`ifdef MEM_ADDR_CHECK_EN
        err_nxt     = err_q;
`endif

        case (state)
            IDLE: begin
                ready_c = ~req;
                start   = req;
`ifdef MEM_ADDR_CHECK_EN
                if (req && out_of_range) begin
                    start   = 1'b0;
                    ready_c = 1'b1;
                    err_nxt = 1'b1;
                    if (!bus.mem_w_en) begin
                        rd_nxt = '0;
                    end
                end
`endif
                if (start) begin
                    // a simultaneous read+write request is treated as a write
                    is_wr_nxt   = bus.mem_w_en;
                    word_nxt    = offset[SRAM_AW:2];
                    st_nxt      = bus.st_val;
                    counter_nxt = '0;
                    state_nxt   = LO;
                    addr_nxt    = {offset[SRAM_AW:2], 1'b0};
                    dq_nxt      = bus.mem_w_en ? bus.st_val[15:0] : sram_dq_out;
                    oe_nxt      = bus.mem_w_en;
                    we_n_nxt    = ~bus.mem_w_en;
                end
            end

            LO: begin
                counter_nxt = counter + 1'b1;
                if (counter == CNT_LAST) begin
                    if (!is_wr) begin
                        rd_nxt[15:0] = sram_dq_in;
                    end
                    counter_nxt = '0;
                    state_nxt   = HI;
                    addr_nxt    = {word_q, 1'b1};
                    dq_nxt      = is_wr ? st_q[31:16] : sram_dq_out;
                end
            end

            HI: begin
                counter_nxt = counter + 1'b1;
                if (counter == CNT_LAST) begin
                    if (!is_wr) begin
                        rd_nxt[31:16] = sram_dq_in;
                    end
                    counter_nxt = '0;
                    state_nxt   = DONE;
                    oe_nxt      = 1'b0;
                    we_n_nxt    = 1'b1;
                end
            end

            DONE: begin
                ready_c   = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
